// File: rtl/fb_scanout.sv
// fb_scanout: framebuffer scan-out engine.
// On a start pulse it reads the 64x32 monochrome framebuffer one 8-byte row at a time
// through an arbitrated RAM read port into a line buffer. It then streams that row out
// as single pixels with valid/ready handshaking.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   start, busy         frame request (accepted in idle only) / scan in progress
//   mem_read_*          RAM read request, address, grant and data (data one cycle after issue)
//   pixel_valid/ready   pixel stream handshake
//   pixel, pixel_x/y    pixel value and coordinates
//   sof, eol            first pixel of frame / last pixel of row
//   frame_done          one-cycle pulse after the last pixel is accepted
module fb_scanout #(
    parameter logic [11:0] FB_BASE   = 12'h100,
    parameter int unsigned ROW_BYTES = 8,
    parameter int unsigned ROWS      = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        mem_read_enable,
    output logic [11:0] mem_read_address,
    input  logic        mem_grant,
    input  logic [7:0]  mem_read_data,
    output logic        pixel_valid,
    input  logic        pixel_ready,
    output logic        pixel,
    output logic [5:0]  pixel_x,
    output logic [4:0]  pixel_y,
    output logic        sof,
    output logic        eol,
    output logic        frame_done
);

    localparam logic [2:0] LastByte = 3'(ROW_BYTES - 1);
    localparam logic [4:0] LastRow  = 5'(ROWS - 1);
    localparam logic [5:0] LastCol  = 6'd63;

    typedef enum logic [2:0] {StIdle, StFetch, StDrain, StShift, StDone} state_e;

    state_e      state_q, state_d;
    logic [4:0]  row_q, row_d;
    logic [2:0]  issue_idx_q, issue_idx_d;
    logic        capture_q, capture_d;
    logic [2:0]  capture_idx_q, capture_idx_d;
    logic [5:0]  col_q, col_d;
    logic [7:0]  line_buf_q [ROW_BYTES];

    logic [7:0]  cur_byte;
    logic [2:0]  bit_sel;

    always_comb begin
        state_d         = state_q;
        row_d           = row_q;
        issue_idx_d     = issue_idx_q;
        capture_d       = 1'b0;
        capture_idx_d   = capture_idx_q;
        col_d           = col_q;
        mem_read_enable = 1'b0;

        // A capture flagged last cycle lands this cycle, whatever state we are in now.
        if (capture_q) begin
            capture_idx_d = capture_idx_q + 3'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    row_d         = '0;
                    issue_idx_d   = '0;
                    capture_idx_d = '0;
                    col_d         = '0;
                    state_d       = StFetch;
                end
            end
            StFetch: begin
                mem_read_enable = 1'b1;
                if (mem_grant) begin
                    capture_d   = 1'b1;
                    issue_idx_d = issue_idx_q + 3'd1;
                    if (issue_idx_q == LastByte) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                state_d = StShift;
            end
            StShift: begin
                if (pixel_ready) begin
                    col_d = col_q + 6'd1;
                    if (col_q == LastCol) begin
                        if (row_q == LastRow) begin
                            state_d = StDone;
                        end else begin
                            row_d   = row_q + 5'd1;
                            state_d = StFetch;
                        end
                    end
                end
            end
            StDone: begin
                row_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            row_q         <= '0;
            issue_idx_q   <= '0;
            capture_q     <= 1'b0;
            capture_idx_q <= '0;
            col_q         <= '0;
            for (int i = 0; i < ROW_BYTES; i++) begin
                line_buf_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            issue_idx_q   <= issue_idx_d;
            capture_q     <= capture_d;
            capture_idx_q <= capture_idx_d;
            col_q         <= col_d;
            if (capture_q) begin
                line_buf_q[capture_idx_q] <= mem_read_data;
            end
        end
    end

    // Byte k bit 7 is the leftmost pixel of its group of eight.
    assign cur_byte = line_buf_q[col_q[5:3]];
    assign bit_sel  = 3'd7 - col_q[2:0];

    assign mem_read_address = FB_BASE + {4'b0, row_q, 3'b0} + {9'b0, issue_idx_q};
    assign busy             = (state_q == StFetch) || (state_q == StDrain) ||
                              (state_q == StShift);
    assign pixel_valid      = (state_q == StShift);
    assign pixel            = pixel_valid & cur_byte[bit_sel];
    assign pixel_x          = col_q;
    assign pixel_y          = row_q;
    assign sof              = pixel_valid && (row_q == 5'd0) && (col_q == 6'd0);
    assign eol              = pixel_valid && (col_q == LastCol);
    assign frame_done       = (state_q == StDone);

endmodule

// File: tb/tb_fb_scanout.sv
module tb_fb_scanout;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        mem_grant = 1'b1;
    logic        pixel_ready = 1'b1;
    logic [7:0]  mem_read_data = 8'h00;
    logic        busy, mem_read_enable, pixel_valid, pixel, sof, eol, frame_done;
    logic [11:0] mem_read_address;
    logic [5:0]  pixel_x;
    logic [4:0]  pixel_y;

    fb_scanout dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .busy             (busy),
        .mem_read_enable  (mem_read_enable),
        .mem_read_address (mem_read_address),
        .mem_grant        (mem_grant),
        .mem_read_data    (mem_read_data),
        .pixel_valid      (pixel_valid),
        .pixel_ready      (pixel_ready),
        .pixel            (pixel),
        .pixel_x          (pixel_x),
        .pixel_y          (pixel_y),
        .sof              (sof),
        .eol              (eol),
        .frame_done       (frame_done)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          t0       = 0;
    bit          grant_toggle = 1'b0;
    bit          ready_rand   = 1'b0;
    logic [13:0] sb [$];
    int          n_sof, n_eol, n_done, done_cyc, first_rd_cyc, first_pv_cyc, row1_cyc;
    logic [11:0] exp_addr = 12'h100;
    logic [11:0] hold_addr;
    bit          hold_pending = 1'b0;
    bit          stall_pending = 1'b0;
    logic [13:0] stall_vec;
    logic [7:0]  ram [4096];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // RAM model: data one cycle after a granted request; junk otherwise.
    always @(posedge clk) begin
        if (mem_read_enable && mem_grant) mem_read_data <= ram[mem_read_address];
        else mem_read_data <= 8'h3c;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        mem_grant   = grant_toggle ? ~mem_grant : 1'b1;
        pixel_ready = ready_rand ? ($urandom_range(0, 99) < 30) : 1'b1;
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        logic [13:0] cur;
        logic [13:0] exp;
        int          rel;
        rel = cyc - t0;
        cur = {pixel, pixel_x, pixel_y, sof, eol};
        if (!reset) begin
            stall_pending = 1'b0;
            hold_pending  = 1'b0;
        end else begin
            if (stall_pending) begin
                check("stall_valid", {31'b0, pixel_valid}, 32'd1);
                check("stall_hold", {18'b0, cur}, {18'b0, stall_vec});
            end
            stall_pending = pixel_valid && !pixel_ready;
            stall_vec     = cur;
            if (hold_pending) check("addr_hold", {20'b0, mem_read_address}, {20'b0, hold_addr});
            hold_pending = mem_read_enable && !mem_grant;
            hold_addr    = mem_read_address;
            if (mem_read_enable && mem_grant) begin
                check("rd_addr", {20'b0, mem_read_address}, {20'b0, exp_addr});
                exp_addr = exp_addr + 12'd1;
                if (first_rd_cyc < 0) first_rd_cyc = rel;
            end
            if (pixel_valid && first_pv_cyc < 0) first_pv_cyc = rel;
            if (pixel_valid && pixel_y == 5'd1 && pixel_x == 6'd0 && row1_cyc < 0) row1_cyc = rel;
            if (pixel_valid && pixel_ready) begin
                if (sof) n_sof++;
                if (eol) n_eol++;
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_extra_pixel: got pixel %0h with no expected entry", cur);
                end else begin
                    exp = sb.pop_front();
                    check("pixel", {18'b0, cur}, {18'b0, exp});
                end
            end
            if (frame_done) begin
                n_done++;
                done_cyc = rel;
            end
        end
    end

    task automatic push_frame();
        for (int y = 0; y < 32; y++) begin
            for (int x = 0; x < 64; x++) begin
                logic p;
                p = (y == 8) && (x >= 12) && (x <= 19);
                sb.push_back({p, 6'(x), 5'(y), (x == 0 && y == 0), (x == 63)});
            end
        end
    endtask

    task automatic start_frame();
        @(negedge clk);
        t0 = cyc;
        start = 1'b1;
        exp_addr = 12'h100;
        n_sof = 0; n_eol = 0; n_done = 0; done_cyc = -1;
        first_rd_cyc = -1; first_pv_cyc = -1; row1_cyc = -1;
        push_frame();
        @(negedge clk);
        start = 1'b0;
        check("busy_cycle1", {31'b0, busy}, 32'd1);
    endtask

    task automatic wait_done(input string name, input int budget);
        int i = 0;
        while (n_done == 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (n_done == 0) begin
            n_checks++;
            $display("FAIL %s: frame_done not seen within %0d cycles", name, budget);
        end
        repeat (4) @(negedge clk);
        check({name, "_sb_empty"}, sb.size(), 32'd0);
        check({name, "_sof"}, n_sof, 32'd1);
        check({name, "_eol"}, n_eol, 32'd32);
        check({name, "_done_once"}, n_done, 32'd1);
        check({name, "_busy_idle"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_ctrl"}, {25'b0, busy, mem_read_enable, pixel_valid, pixel, sof, eol,
                                frame_done}, 32'd0);
        check({name, "_addr"}, {20'b0, mem_read_address}, 32'h100);
        check({name, "_xy"}, {21'b0, pixel_x, pixel_y}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'ha5;
        for (int i = 12'h100; i < 12'h200; i++) ram[i] = 8'h00;
        ram[12'h141] = 8'h0f;
        ram[12'h142] = 8'hf0;

        repeat (3) @(negedge clk);
        check_reset_values("rst_init");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Pattern frame with an ignored second start at cycle 500.
        start_frame();
        repeat (499) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("pattern", 3000);
        check("lat_first_rd", first_rd_cyc, 32'd1);
        check("lat_first_pv", first_pv_cyc, 32'd10);
        check("lat_row1", row1_cyc, 32'd83);
        check("lat_done", done_cyc, 32'd2337);

        // Arbitration: grant toggling every cycle.
        grant_toggle = 1'b1;
        start_frame();
        wait_done("arb", 5000);
        check("arb_all_granted", {20'b0, exp_addr}, 32'h200);
        grant_toggle = 1'b0;

        // Backpressure: sink ready 30% of cycles.
        ready_rand = 1'b1;
        start_frame();
        wait_done("bp", 20000);
        ready_rand = 1'b0;

        // Reset in the middle of a frame.
        start_frame();
        repeat (999) @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_values("rst_mid");
        sb.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_no_valid", {31'b0, pixel_valid}, 32'd0);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_valid", {31'b0, pixel_valid}, 32'd0);

        // Full frame after the reset.
        start_frame();
        wait_done("post_rst", 3000);
        check("post_rst_first_pv", first_pv_cyc, 32'd10);
        check("post_rst_done", done_cyc, 32'd2337);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fb_scanout.md
# fb_scanout

Framebuffer scan-out engine for the CHIP-8 core. The PPU writes sprites into the 64x32 monochrome framebuffer held in chip8_ram. This block is the reader on the other side of that buffer. On a start pulse it fetches the framebuffer one row (8 bytes) at a time through a shared, arbitrated RAM read port. It then serialises each row into a 1-bit pixel stream with valid/ready flow control, for a display back end (VGA scaler or LED matrix driver).

## Interface
- FB_BASE, 12'h100, RAM byte address of framebuffer row 0, byte 0
- ROW_BYTES, 8, bytes per framebuffer row (64 pixels)
- ROWS, 32, framebuffer rows per frame

- clk  in  1  single clock; all logic is rising-edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to scan one full frame; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until frame_done
- mem_read_enable  out  1  read request to the RAM arbiter
- mem_read_address  out  12  byte address of the request
- mem_grant  in  1  arbiter grant; a request is issued in a cycle where mem_read_enable && mem_grant
- mem_read_data  in  8  RAM data, valid exactly one cycle after the issuing cycle
- pixel_valid  out  1  pixel, pixel_x, pixel_y, sof and eol are valid
- pixel_ready  in  1  sink accepts the pixel in a cycle where pixel_valid && pixel_ready
- pixel  out  1  pixel value (1 = lit)
- pixel_x  out  6  column 0..63
- pixel_y  out  5  row 0..31
- sof  out  1  high with pixel (0,0)
- eol  out  1  high with pixel_x == 63
- frame_done  out  1  one-cycle pulse after the last pixel of the frame is accepted

## Operation
- States: IDLE, FETCH, DRAIN, SHIFT, DONE.
- IDLE
  - start=1: clear row counter, go to FETCH.
  - start is ignored in every other state; no queuing.
- FETCH
  - mem_read_enable=1, mem_read_address = FB_BASE + row*ROW_BYTES + issue_idx (12-bit, wraps mod 4096).
  - The address is held until granted; issue_idx increments only on a granted cycle.
  - Each granted issue sets a capture flag; the next cycle writes mem_read_data into line_buf[capture_idx] and increments capture_idx.
  - After the granted issue with issue_idx == ROW_BYTES-1, go to DRAIN.
- DRAIN
  - mem_read_enable=0.
  - Capture the last byte, go to SHIFT.
- SHIFT
  - Present line_buf bit-serially.
  - Byte k bit 7 is pixel_x = 8k; bit 0 is pixel_x = 8k+7 (MSB leftmost, matching the PPU's writer convention).
  - The column counter advances only on accept.
  - After accepting pixel_x=63: if row == ROWS-1, go to DONE; else row++ and go to FETCH.
- DONE
  - frame_done=1, busy=0, go to IDLE.
- Line buffer is single-buffered: no RAM reads while in SHIFT.
- Output stability: while pixel_valid && !pixel_ready, all pixel_* outputs, sof and eol hold stable.
- Reset (async, any state) returns to IDLE, clears counters and drops a pending capture. The next start scans a complete frame from row 0.

## Timing
- Reset values: busy, mem_read_enable, pixel_valid, pixel, sof, eol, frame_done = 0; mem_read_address = FB_BASE; pixel_x = 0, pixel_y = 0.
- With mem_grant=1 and pixel_ready=1 held, start sampled at cycle 0:
  - busy=1 and the first read (FB_BASE) issue at cycle 1.
  - Reads issue at cycles 1..8; last byte captured at cycle 9.
  - First pixel_valid with sof=1 at cycle 10.
- Per row: 8 issue + 1 drain + 64 shift = 73 cycles.
- Frame: last pixel accepted at cycle 32*73 = 2336; frame_done=1, busy=0 at cycle 2337; start is accepted again from cycle 2338.
- Each denied grant cycle adds exactly one cycle.
- Each pixel_ready=0 cycle while valid adds exactly one cycle.

## Test plan
- Reset: hold reset=0 mid-run → all outputs at the reset values above; pixel_valid stays 0 with start=0.
- Pattern frame: RAM 0x100..0x1FF zero except 0x141=0x0f and 0x142=0xf0. Start with grant=ready=1 → 2048 pixels; pixel=1 only at y=8, x=12..19. sof once; eol 32 times; frame_done once at cycle 2337.
- Arbitration: mem_grant toggling 1010… → same pixel stream as the pattern frame. Each address 0x100..0x1FF is granted exactly once, in ascending order; address stable during denied cycles.
- Backpressure: pixel_ready random at 30% → same pixel stream; outputs unchanged across every stalled cycle; no pixel dropped or duplicated.
- Start hazards: a second start at cycle 500 is ignored, so exactly one frame_done. Reset asserted at cycle 1000, then a new start → a full 2048-pixel frame beginning at (0,0) with sof.
- Latency: grant=ready=1 → first read at cycle 1, first pixel_valid at cycle 10, first pixel of row 1 at cycle 83.
